// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one 8x8 unsigned Dadda multiplier among NREQ requesters.
// Latency: accept at edge N gives a tagged response valid after edge N+1; 1 job/cycle sustained.
// Backpressure: response held while !rsp_ready; operand stage stalls behind it, then req_ready drops.

module dada_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] y
);
  // Partial products, then carry-save reduction through the Dadda heights 8 -> 6 -> 4 -> 3 -> 2.
  logic [15:0] pp [8];
  logic [15:0] s1 [6];
  logic [15:0] s2 [4];
  logic [15:0] s3 [3];
  logic [15:0] s4 [2];

  function automatic logic [15:0] fa_s(input logic [15:0] x, input logic [15:0] p, input logic [15:0] q);
    return x ^ p ^ q;
  endfunction

  function automatic logic [15:0] fa_c(input logic [15:0] x, input logic [15:0] p, input logic [15:0] q);
    return ((x & p) | (x & q) | (p & q)) << 1;
  endfunction

  // Shifted AND rows, one per bit of b.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = {8'd0, a & {8{b[i]}}} << i;
    end
  end

  assign s1[0] = fa_s(pp[0], pp[1], pp[2]);
  assign s1[1] = fa_c(pp[0], pp[1], pp[2]);
  assign s1[2] = fa_s(pp[3], pp[4], pp[5]);
  assign s1[3] = fa_c(pp[3], pp[4], pp[5]);
  assign s1[4] = pp[6];
  assign s1[5] = pp[7];

  assign s2[0] = fa_s(s1[0], s1[1], s1[2]);
  assign s2[1] = fa_c(s1[0], s1[1], s1[2]);
  assign s2[2] = fa_s(s1[3], s1[4], s1[5]);
  assign s2[3] = fa_c(s1[3], s1[4], s1[5]);

  assign s3[0] = fa_s(s2[0], s2[1], s2[2]);
  assign s3[1] = fa_c(s2[0], s2[1], s2[2]);
  assign s3[2] = s2[3];

  assign s4[0] = fa_s(s3[0], s3[1], s3[2]);
  assign s4[1] = fa_c(s3[0], s3[1], s3[2]);

  // Final carry-propagate add; the product always fits in 16 bits.
  assign y = s4[0] + s4[1];
endmodule

module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_y
);
  logic           op_v;
  logic [7:0]     op_a;
  logic [7:0]     op_b;
  logic [IDW-1:0] op_id;
  logic [IDW-1:0] rr_ptr;
  logic           res_free;
  logic           op_adv;
  logic           op_free;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   scan_idx;
  logic [15:0]    mul_y;

  assign res_free = !rsp_valid || rsp_ready;
  assign op_adv   = op_v && res_free;
  assign op_free  = !op_v || op_adv;

  // Round-robin search from rr_ptr upward with wrap; grant only when the operand stage can take a job.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    if (op_free) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
        if (scan_idx >= (IDW+1)'(NREQ)) begin
          scan_idx = scan_idx - (IDW+1)'(NREQ);
        end
        if (!gnt_any && req_valid[scan_idx[IDW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx[IDW-1:0];
        end
      end
    end
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Operand stage and round-robin pointer; the pointer moves only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_v   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
      rr_ptr <= '0;
    end else if (gnt_any) begin
      op_v   <= 1'b1;
      op_a   <= req_a[8*gnt_idx +: 8];
      op_b   <= req_b[8*gnt_idx +: 8];
      op_id  <= gnt_idx;
      rr_ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end else if (op_adv) begin
      op_v <= 1'b0;
    end
  end

  dada_mul u_mul (
    .a (op_a),
    .b (op_b),
    .y (mul_y)
  );

  // Product stage: load on advance, otherwise drop valid once consumed and keep the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
    end else if (op_adv) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_y     <= mul_y;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios plus a randomized job sweep.
// Expected grants, response timing and products come from a queue-based model of the spec rules.
// A monitor process pops expected (id, product) pairs whenever a response handshake happens.

module tb_mul_share_arb;
  localparam int N = 4;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] y;
    int          cyc;
  } job_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [15:0]    rsp_y;

  logic [2:0]     v3;
  logic [23:0]    a3;
  logic [23:0]    b3;
  logic [2:0]     r3;
  logic           rsp3_v;
  logic           rsp3_rdy;
  logic [1:0]     rsp3_id;
  logic [15:0]    rsp3_y;

  mul_share_arb #(.NREQ(N), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y)
  );

  mul_share_arb #(.NREQ(3), .IDW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_a(a3), .req_b(b3),
    .req_ready(r3), .rsp_valid(rsp3_v), .rsp_ready(rsp3_rdy),
    .rsp_id(rsp3_id), .rsp_y(rsp3_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  job_t        q[$];
  int          errors = 0;
  int          checks = 0;
  bit          pend[N];
  logic [7:0]  pa[N];
  logic [7:0]  pb[N];
  int          rr = 0;
  int          cyc = 0;
  int          accepts = 0;
  int          responses = 0;
  bit          refill = 0;
  int          rand_load = 0;
  int          rand_rdy = -1;
  bit          rdy_set = 1;
  bit          stall_prev = 0;
  logic [1:0]  prev_id;
  logic [15:0] prev_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check grant/valid just after, update the model for the coming edge.
  task automatic cycle();
    int         g;
    int         idx;
    logic [3:0] exp_rdy;
    bit         exp_v;
    logic [15:0] prod;
    @(negedge clk);
    cyc++;
    if (rand_load > 0) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(99) < rand_load) begin
          pend[i] = 1'b1;
          pa[i] = 8'($urandom);
          pb[i] = 8'($urandom);
        end
      end
    end
    if (rand_rdy >= 0) rsp_ready = ($urandom_range(99) < rand_rdy);
    else rsp_ready = rdy_set;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_a[8*i +: 8] = pa[i];
      req_b[8*i +: 8] = pb[i];
    end
    #1;
    g = -1;
    if (q.size() < 2 || rsp_ready) begin
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    exp_v = (q.size() > 0) && (cyc - q[0].cyc >= 2);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (g >= 0) begin
      prod = {8'd0, pa[g]} * {8'd0, pb[g]};
      q.push_back('{2'(g), prod, cyc});
      accepts++;
      rr = (g + 1) % N;
      if (!refill) pend[g] = 1'b0;
    end
  endtask

  // Monitor: compare each consumed response with the oldest expected job; check hold under stall.
  initial begin
    job_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid) begin
        if (stall_prev) begin
          chk("hold_id", 32'(rsp_id), 32'(prev_id));
          chk("hold_y", 32'(rsp_y), 32'(prev_y));
        end
        if (rsp_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got id %0d y %0h expected no response", rsp_id, rsp_y);
          end else begin
            e = q.pop_front();
            responses++;
            if (rsp_id !== e.id || rsp_y !== e.y) begin
              errors++;
              $display("FAIL rsp_data: got id %0d y %0h expected id %0d y %0h", rsp_id, rsp_y, e.id, e.y);
            end
          end
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      prev_id = rsp_id;
      prev_y = rsp_y;
    end
  end

  initial begin
    int cnt;
    int target;
    int budget;
    logic [7:0] ea[3];
    logic [7:0] eb[3];
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    v3 = '0;
    a3 = '0;
    b3 = '0;
    rsp3_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pa[i] = '0;
      pb[i] = '0;
    end
    #12;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_rsp_y", 32'(rsp_y), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;

    // Single job with maximum operands.
    pend[0] = 1'b1; pa[0] = 8'd255; pb[0] = 8'd255;
    cnt = 0;
    repeat (5) begin
      cycle();
      if (req_ready[0]) cnt++;
    end
    chk("single_grant_once", cnt, 1);

    // All requesters held valid: strict rotation, one response per cycle.
    refill = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pa[i] = 8'(i + 3); pb[i] = 8'(i + 7);
    end
    repeat (12) cycle();
    refill = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (4) cycle();

    // Backpressure: three jobs, consumer stalled, then drained.
    rdy_set = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b1; pa[i] = 8'(17 * i + 5); pb[i] = 8'(29 * i + 11);
    end
    repeat (8) cycle();
    chk("bp_inflight", q.size(), 2);
    rdy_set = 1'b1;
    repeat (6) cycle();
    chk("bp_drained", q.size(), 0);

    // Edge operands on one requester.
    ea = '{8'd0, 8'd1, 8'd128};
    eb = '{8'd200, 8'd255, 8'd2};
    for (int i = 0; i < 3; i++) begin
      pend[1] = 1'b1; pa[1] = ea[i]; pb[1] = eb[i];
      repeat (3) cycle();
    end

    // Randomized sweep of 1000 jobs with random consumer stalls.
    rand_load = 30;
    rand_rdy = 75;
    target = accepts + 1000;
    budget = 0;
    while (accepts < target && budget < 20000) begin
      cycle();
      budget++;
    end
    checks++;
    if (accepts < target) begin
      errors++;
      $display("FAIL sweep_budget: got %0d accepts expected %0d", accepts, target);
    end
    rand_load = 0;
    rand_rdy = -1;
    rdy_set = 1'b1;
    repeat (10) cycle();
    chk("sweep_drained", q.size(), 0);
    chk("accepts_vs_responses", responses, accepts);

    // Reset with two jobs in flight.
    rdy_set = 1'b0;
    pend[1] = 1'b1; pa[1] = 8'd77; pb[1] = 8'd3;
    pend[2] = 1'b1; pa[2] = 8'd66; pb[2] = 8'd4;
    budget = 0;
    while (q.size() < 2 && budget < 10) begin
      cycle();
      budget++;
    end
    chk("rst_two_inflight", q.size(), 2);
    @(posedge clk);
    #2;
    chk("rst_pre_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_y", 32'(rsp_y), 0);
    accepts -= q.size();
    q.delete();
    rr = 0;
    stall_prev = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    #1;
    rst_n = 1'b1;
    rdy_set = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; pa[i] = 8'(40 + i); pb[i] = 8'(50 + i);
    end
    cycle();
    chk("rst_first_grant", 32'(req_ready), 32'h1);
    repeat (8) cycle();
    chk("rst_drained", q.size(), 0);

    // Three-requester build: pointer wraps 2 -> 0 and never names index 3.
    a3 = {8'd9, 8'd5, 8'd4};
    b3 = {8'd11, 8'd6, 8'd7};
    @(negedge clk);
    v3 = 3'b010;
    #1 chk("wrap_g1", 32'(r3), 32'b010);
    @(negedge clk);
    v3 = 3'b101;
    #1 chk("wrap_g2", 32'(r3), 32'b100);
    @(negedge clk);
    #1 chk("wrap_g3", 32'(r3), 32'b001);
    @(negedge clk);
    #1 chk("wrap_g4", 32'(r3), 32'b100);
    chk("wrap_rsp_id", 32'(rsp3_id), 2);
    chk("wrap_rsp_y", 32'(rsp3_y), 99);
    @(negedge clk);
    v3 = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
